wb_hyper_arbiter: RTL and testbench
===================================

Name: wb_hyper_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single wb_hyper data slave port among NUM_MASTERS requesters (e.g. CPU, sensor capture DMA, SD writer DMA).
- Locks the grant for the full duration of a master's cyc, so HyperRAM bursts (cti 010 … 111) are never interleaved.
- Sits between the masters and wb_hyper.wb_*; the cfg port of wb_hyper is not arbitrated by this block.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, cycles without ack before a forced error (optional feature only)

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  reset, asynchronous, active-low
m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW]
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*DW/8  master byte selects
m_we_i  in  NUM_MASTERS  master write enables
m_cti_i  in  NUM_MASTERS*3  master cycle type identifiers
m_cyc_i  in  NUM_MASTERS  master cycle requests
m_stb_i  in  NUM_MASTERS  master strobes
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master error
s_adr_o  out  AW  to wb_hyper wb_adr_i
s_dat_o  out  DW  to wb_hyper wb_dat_i
s_sel_o  out  DW/8  to wb_hyper wb_sel_i
s_we_o  out  1  to wb_hyper wb_we_i
s_cti_o  out  3  to wb_hyper wb_cti_i
s_cyc_o  out  1  to wb_hyper wb_cyc_i
s_stb_o  out  1  to wb_hyper wb_stb_i
s_dat_i  in  DW  from wb_hyper wb_dat_o
s_ack_i  in  1  from wb_hyper wb_ack_o
gnt_o  out  NUM_MASTERS  one-hot current grant, for debug/status

Behaviour:
- Reset (wb_rst low, async): state IDLE, gnt_o = 0, last = NUM_MASTERS-1 so master 0 wins first. s_cyc_o, s_stb_o, s_we_o = 0; s_cti_o, s_adr_o, s_dat_o, s_sel_o = 0; m_ack_o, m_err_o = 0.
- State IDLE:
  - If any m_cyc_i bit is set, pick the first set bit searching upward from last+1 (wrapping), register it into gnt_o and go to GRANT.
  - Arbitration latency: exactly 1 cycle from cyc to grant.
- State GRANT:
  - Slave outputs combinationally mux the granted master's signals.
  - s_cyc_o = granted m_cyc_i; s_stb_o = granted m_cyc_i & m_stb_i.
  - m_ack_o[g] = s_ack_i; all other ack and err bits are 0.
  - m_dat_o = s_dat_i, unmuxed.
- Release: when the granted m_cyc_i goes low, set last = g, clear gnt_o, go to IDLE.
  - This guarantees at least one cycle with s_cyc_o low between owners.
  - A new grant is decided in that IDLE cycle, including re-granting the same master if it is the only requester.
- Non-granted masters see no ack and stall indefinitely; requests arriving mid-grant have no effect on the current owner.
- Simultaneous requests: round-robin order strictly from last+1.
- s_ack_i arriving while in IDLE is ignored and not routed to any master.
- Reset asserted mid-burst: all outputs drop to reset values immediately; masters must restart their cycles.

Optional Feature:
- Macro WB_HYPER_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on every s_ack_i and on each new grant, and increments each GRANT cycle with s_stb_o high and no ack.
  - On reaching TIMEOUT: pulse m_err_o[g] for 1 cycle, force s_cyc_o and s_stb_o low, go to IDLE with last = g.
  - Any ack that arrives later is discarded.
- Undefined: no counter; m_err_o is tied to 0.

Test Plan:
- Single master 0 write 0x12345678 to addr 0 then read → s_cyc_o follows after 1-cycle grant, read returns 0x12345678, gnt_o = 01.
- Masters 0 and 1 raise cyc in the same cycle, both doing 4-beat bursts (cti 010,010,010,111) → master 0 gets all 4 acks first; at least 1 idle s_cyc_o cycle; then master 1 gets 4 acks; no interleaved acks.
- Master 1 holds cyc while master 0 re-requests repeatedly → grants alternate 0,1,0,1, with no starvation over 8 transactions.
- Reset pulled low mid-burst (beat 2 of 4) → s_cyc_o = 0 and gnt_o = 0 within the same cycle; after release, master 0 is granted first.
- Stray s_ack_i injected in IDLE → no m_ack_o bit asserts.
- With WB_HYPER_ARB_TIMEOUT_EN and TIMEOUT=16, slave never acks → m_err_o[0] pulses 1 cycle at stb+16 cycles, s_cyc_o drops, and a waiting master 1 is granted next.

Source files
------------

// File: rtl/wb_hyper_arbiter.sv
// rtl/wb_hyper_arbiter.sv - round-robin Wishbone arbiter in front of the wb_hyper data port
// Optional ack watchdog enabled by defining WB_HYPER_ARB_TIMEOUT_EN.

module wb_hyper_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  output logic [NUM_MASTERS-1:0]      gnt_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_hyper_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT positive");
  end

  logic [0:0]             state;
  logic [NUM_MASTERS-1:0] gnt;
  logic [LW-1:0]          last;
  logic [LW-1:0]          g_idx;
  logic [LW-1:0]          pick;
  logic                   pick_vld;
  logic [LW:0]            rr_sum;
  logic                   to_hit;

  // Search upward from last+1 with wrap; the extra sum bit absorbs the carry
  // so non-power-of-two master counts wrap correctly.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      rr_sum = {1'b0, last} + (LW+1)'(i);
      if (rr_sum >= (LW+1)'(NUM_MASTERS)) begin
        rr_sum = rr_sum - (LW+1)'(NUM_MASTERS);
      end
      if (!pick_vld && m_cyc_i[rr_sum[LW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_sum[LW-1:0];
      end
    end
  end

`ifdef WB_HYPER_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 256) ? 8 : 16;

  logic [CW-1:0] to_cnt;

  assign to_hit = (state == S_GRANT) && (to_cnt == CW'(TIMEOUT));

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || s_ack_i) begin
      to_cnt <= '0;
    end else if (s_stb_o) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      last  <= LW'(NUM_MASTERS - 1);
      g_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            state <= S_GRANT;
            g_idx <= pick;
            gnt   <= NUM_MASTERS'(1) << pick;
          end
        end
        default: begin
          // The owner keeps the port until its cyc drops, so bursts stay whole.
          if (to_hit || !m_cyc_i[g_idx]) begin
            state <= S_IDLE;
            last  <= g_idx;
            gnt   <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state == S_GRANT) begin
      s_adr_o = m_adr_i[int'(g_idx)*AW +: AW];
      s_dat_o = m_dat_i[int'(g_idx)*DW +: DW];
      s_sel_o = m_sel_i[int'(g_idx)*SW +: SW];
      s_we_o  = m_we_i[g_idx];
      s_cti_o = m_cti_i[int'(g_idx)*3 +: 3];
      // A timed-out owner loses cyc/stb and any late ack in the same cycle.
      if (!to_hit) begin
        s_cyc_o        = m_cyc_i[g_idx];
        s_stb_o        = m_cyc_i[g_idx] & m_stb_i[g_idx];
        m_ack_o[g_idx] = s_ack_i;
      end
      m_err_o[g_idx] = to_hit;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_hyper_arbiter.sv
// tb/tb_wb_hyper_arbiter.sv - self-checking bench for wb_hyper_arbiter
// Directed scenarios plus randomized traffic against a behavioural arbitration model.

module tb_wb_hyper_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef WB_HYPER_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            wb_clk = 1'b0;
  logic            wb_rst = 1'b0;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N*SW-1:0] m_sel_i = '0;
  logic [N-1:0]    m_we_i  = '0;
  logic [N*3-1:0]  m_cti_i = '0;
  logic [N-1:0]    m_cyc_i = '0;
  logic [N-1:0]    m_stb_i = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_we_o;
  logic [2:0]      s_cti_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;
  logic [N-1:0]    gnt_o;

  logic          directed  = 1'b1;
  logic          ack_en    = 1'b1;
  logic          stray_ack = 1'b0;
  logic          rnd_ack   = 1'b0;
  logic [DW-1:0] rnd_dat   = '0;
  logic [DW-1:0] mem [16];

  int checks   = 0;
  int failures = 0;

  wb_hyper_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cti_i(m_cti_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 wb_clk = ~wb_clk;

  // Slave: zero-wait-state memory in directed mode, random responder otherwise.
  assign s_ack_i = directed ? ((ack_en & s_cyc_o & s_stb_o) | stray_ack) : rnd_ack;
  assign s_dat_i = directed ? mem[s_adr_o[5:2]] : rnd_dat;

  always @(posedge wb_clk)
    if (directed && s_cyc_o && s_stb_o && s_we_o && s_ack_i) mem[s_adr_o[5:2]] <= s_dat_o;

  // Reference model: who owns the port, who owned it last, stalled beats.
  int owner  = -1;
  int last_m = N - 1;
  int stall  = 0;

  function automatic int rr_pick(input int lst, input logic [N-1:0] cyc);
    for (int i = 1; i <= N; i++)
      if (cyc[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  always @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      owner  <= -1;
      last_m <= N - 1;
      stall  <= 0;
    end else if (owner < 0) begin
      owner <= rr_pick(last_m, m_cyc_i);
      stall <= 0;
    end else if ((TO_EN && stall == TO) || !m_cyc_i[owner]) begin
      last_m <= owner;
      owner  <= -1;
    end else if (s_ack_i) begin
      stall <= 0;
    end else if (m_stb_i[owner]) begin
      stall <= stall + 1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit hit, act;
    logic [N-1:0] e_gnt, e_ack, e_err;
    hit   = TO_EN && owner >= 0 && stall == TO;
    act   = owner >= 0 && !hit;
    e_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
    e_ack = act ? (N'(s_ack_i) << owner) : '0;
    e_err = hit ? (N'(1) << owner) : '0;
    check("gnt_o", gnt_o, e_gnt);
    check("m_ack_o", m_ack_o, e_ack);
    check("m_err_o", m_err_o, e_err);
    check("s_cyc_o", s_cyc_o, act ? m_cyc_i[owner] : 1'b0);
    check("s_stb_o", s_stb_o, act ? (m_cyc_i[owner] & m_stb_i[owner]) : 1'b0);
    check("s_we_o", s_we_o, (owner >= 0) ? m_we_i[owner] : 1'b0);
    check("s_adr_o", s_adr_o, (owner >= 0) ? m_adr_i[owner*AW +: AW] : '0);
    check("s_dat_o", s_dat_o, (owner >= 0) ? m_dat_i[owner*DW +: DW] : '0);
    check("s_sel_o", s_sel_o, (owner >= 0) ? m_sel_i[owner*SW +: SW] : '0);
    check("s_cti_o", s_cti_o, (owner >= 0) ? m_cti_i[owner*3 +: 3] : '0);
    check("m_dat_o", m_dat_o, s_dat_i);
  endtask

  initial forever begin
    @(negedge wb_clk);
    compare();
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [2:0] cti);
    m_cyc_i[k] = cyc;
    m_stb_i[k] = stb;
    m_we_i[k]  = we;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat;
    m_sel_i[k*SW +: SW] = '1;
    m_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic clear_m();
    for (int k = 0; k < N; k++) set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
  endtask

  task automatic do_reset();
    wb_rst = 1'b0;
    clear_m();
    @(posedge wb_clk);
    #1 wb_rst = 1'b1;
  endtask

  task automatic wait_ack(input int k, input string nm);
    int n;
    n = 0;
    @(negedge wb_clk);
    while (!m_ack_o[k] && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    check(nm, n < 20, 1'b1);
  endtask

  // Burst engine: each master runs txn_left transactions of beats_cfg beats,
  // idling one cycle between its own transactions.
  int beats_cfg [N];
  int txn_left  [N];
  int beat_left [N];
  bit cool      [N];
  int ack_log   [$];
  int done_log  [$];
  int gap_at;
  int gap_cnt;

  task automatic run_engine(input int budget, input string nm);
    bit acked [N];
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    for (int k = 0; k < N; k++) begin
      acked[k] = 1'b0;
      cool[k]  = 1'b0;
    end
    while (n < budget) begin
      busy = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_cyc_i[k]) begin
          if (acked[k]) begin
            beat_left[k]--;
            if (beat_left[k] == 0) begin
              set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
              txn_left[k]--;
              done_log.push_back(k);
              cool[k] = 1'b1;
            end else begin
              set_m(k, 1'b1, 1'b1, 1'b1, m_adr_i[k*AW +: AW] + 4, $urandom,
                    (beat_left[k] == 1) ? 3'b111 : 3'b010);
            end
          end
        end else if (cool[k]) begin
          cool[k] = 1'b0;
        end else if (txn_left[k] > 0) begin
          beat_left[k] = beats_cfg[k];
          set_m(k, 1'b1, 1'b1, 1'b1, AW'(k * 256), $urandom,
                (beats_cfg[k] == 1) ? 3'b111 : 3'b010);
        end
        if (m_cyc_i[k] || txn_left[k] > 0) busy = 1'b1;
      end
      if (!busy) break;
      @(negedge wb_clk);
      if (ack_log.size() == gap_at && !s_cyc_o) gap_cnt++;
      for (int k = 0; k < N; k++) begin
        acked[k] = m_ack_o[k];
        if (m_ack_o[k]) ack_log.push_back(k);
      end
      @(posedge wb_clk);
      #1;
      n++;
    end
    check({nm, "_finished"}, busy, 1'b0);
  endtask

  initial begin
    int n, acks;
    int exp3 [8];
    int exp4 [8];
    exp3 = '{0, 0, 0, 0, 1, 1, 1, 1};
    exp4 = '{0, 1, 0, 1, 0, 1, 0, 1};

    // Reset state
    @(negedge wb_clk);
    check("rst_gnt", gnt_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_stb", s_stb_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_adr", s_adr_o, 0);
    @(posedge wb_clk);
    #1 wb_rst = 1'b1;

    // Single master write then read back
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 3'b111);
    @(negedge wb_clk);
    check("t2_latency_cyc", s_cyc_o, 0);
    @(negedge wb_clk);
    check("t2_grant_cyc", s_cyc_o, 1);
    check("t2_grant_gnt", gnt_o, 3'b001);
    check("t2_write_ack", m_ack_o, 3'b001);
    @(posedge wb_clk);
    #1 clear_m();
    @(posedge wb_clk);
    #1 set_m(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b111);
    wait_ack(0, "t2_read_ack");
    check("t2_read_data", m_dat_o, 32'h1234_5678);
    @(posedge wb_clk);
    #1 clear_m();
    repeat (3) @(posedge wb_clk);
    #1;

    // Two simultaneous 4-beat bursts
    do_reset();
    ack_log.delete();
    done_log.delete();
    beats_cfg = '{4, 4, 0};
    txn_left  = '{1, 1, 0};
    gap_at = 4;
    gap_cnt = 0;
    run_engine(100, "t3");
    check("t3_ack_count", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      check($sformatf("t3_ack%0d_owner", i), ack_log[i], exp3[i]);
    check("t3_idle_gap", gap_cnt >= 1, 1'b1);
    repeat (3) @(posedge wb_clk);
    #1;

    // Fairness: alternating single-beat transactions
    do_reset();
    ack_log.delete();
    done_log.delete();
    beats_cfg = '{1, 1, 0};
    txn_left  = '{4, 4, 0};
    gap_at = -1;
    gap_cnt = 0;
    run_engine(200, "t4");
    check("t4_txn_count", done_log.size(), 8);
    for (int i = 0; i < 8 && i < done_log.size(); i++)
      check($sformatf("t4_txn%0d_owner", i), done_log[i], exp4[i]);
    repeat (3) @(posedge wb_clk);
    #1;

    // Reset mid-burst
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h0, $urandom, 3'b010);
    acks = 0;
    n = 0;
    while (acks < 2 && n < 20) begin
      @(negedge wb_clk);
      if (m_ack_o[0]) acks++;
      n++;
    end
    check("t5_two_acks", acks, 2);
    #2 wb_rst = 1'b0;
    #1;
    check("t5_rst_cyc", s_cyc_o, 0);
    check("t5_rst_gnt", gnt_o, 0);
    clear_m();
    @(posedge wb_clk);
    #1 wb_rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, '0, 3'b111);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, '0, 3'b111);
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("t5_first_gnt", gnt_o, 3'b001);
    @(posedge wb_clk);
    #1 clear_m();
    repeat (3) @(posedge wb_clk);
    #1;

    // Stray slave ack while idle
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      check($sformatf("t6_stray_ack%0d", i), m_ack_o, 0);
    end
    @(posedge wb_clk);
    #1 stray_ack = 1'b0;

`ifdef WB_HYPER_ARB_TIMEOUT_EN
    // Slave never acks: watchdog errors master 0, master 1 takes over
    do_reset();
    ack_en = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, '0, 3'b010);
    @(posedge wb_clk);
    #1 set_m(1, 1'b1, 1'b1, 1'b0, 32'h80, '0, 3'b010);
    n = 0;
    @(negedge wb_clk);
    while (!(gnt_o[0] && s_stb_o) && n < 10) begin
      @(negedge wb_clk);
      n++;
    end
    check("t7_grant0", n < 10, 1'b1);
    n = 0;
    while (!m_err_o[0] && n < 40) begin
      @(negedge wb_clk);
      n++;
    end
    check("t7_err_cycle", n, TO);
    check("t7_err_cyc_low", s_cyc_o, 0);
    @(negedge wb_clk);
    check("t7_err_pulse", m_err_o, 0);
    check("t7_idle_gnt", gnt_o, 0);
    @(negedge wb_clk);
    check("t7_next_gnt", gnt_o, 3'b010);
    @(posedge wb_clk);
    #1 clear_m();
    ack_en = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
`endif

    // Random traffic against the model
    do_reset();
    directed = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (m_cyc_i[k]) m_cyc_i[k] = ($urandom_range(0, 5) != 0);
        else            m_cyc_i[k] = ($urandom_range(0, 2) == 0);
        m_stb_i[k] = ($urandom_range(0, 3) != 0);
        m_we_i[k]  = $urandom_range(0, 1);
        m_adr_i[k*AW +: AW] = $urandom;
        m_dat_i[k*DW +: DW] = $urandom;
        m_sel_i[k*SW +: SW] = SW'($urandom);
        m_cti_i[k*3 +: 3]   = 3'($urandom);
      end
      rnd_ack = $urandom_range(0, 1);
      rnd_dat = $urandom;
      wb_rst  = ($urandom_range(0, 399) != 0);
      @(posedge wb_clk);
      #1;
    end
    wb_rst = 1'b1;
    clear_m();
    repeat (3) @(posedge wb_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
